serial_ripple_borrow_sub: RTL and testbench

//   Bit-serial W-bit subtractor (one borrow-ripple stage per clock, LSB first): computes A - B - Bin.

---
 rtl/sub_pkg.sv | 17 +
 rtl/full_subtractor_1b.sv | 13 +
 rtl/serial_ripple_borrow_sub.sv | 82 ++++++++
 tb/tb_serial_ripple_borrow_sub.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// sub_pkg: shared FSM encoding and sizing helpers for the serial borrow subtractor
package sub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/full_subtractor_1b.sv
// full_subtractor_1b: one-bit difference and borrow stage, reused every clock
module full_subtractor_1b (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_borrow_sub.sv
// serial_ripple_borrow_sub: bit-serial A - B - Bin, LSB first, one borrow stage per clock
module serial_ripple_borrow_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] d_next;

    full_subtractor_1b u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nxt)
    );

    assign d_next = {d_bit, d_sr[WIDTH-1:1]};

    // Control FSM plus datapath shift registers; D/Bout are only written on the final shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            br    <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    a_sr  <= A;
                    b_sr  <= B;
                    br    <= Bin;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= ST_RUN;
                end
            end else begin
                a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                d_sr <= d_next;
                br   <= br_nxt;
                cnt  <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    D     <= d_next;
                    Bout  <= br_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_ripple_borrow_sub.sv
// tb_serial_ripple_borrow_sub: randomized and directed scoreboard bench for the serial subtractor
module tb_serial_ripple_borrow_sub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         Bin = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] D;
    logic         Bout;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ndone = 0;
    int nops = 0;
    logic [W-1:0] pd = '0;
    logic         pb = 1'b0;

    serial_ripple_borrow_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .D     (D),
        .Bout  (Bout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: on every done pulse pop the oldest expectation; between pulses outputs must hold
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                ndone++;
                chk("expected_pending", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("D", int'(D), int'(e.d));
                    chk("Bout", int'(Bout), int'(e.bo));
                    chk("latency", cyc, e.acc + W);
                    chk("busy_at_done", int'(busy), 0);
                end
            end else begin
                chk("D_hold", int'(D), int'(pd));
                chk("Bout_hold", int'(Bout), int'(pb));
            end
        end
        pd = D;
        pb = Bout;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input bit want_done);
        int diff;
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("issue_timeout", int'(busy), 0);
        if (want_done) chk("btb_no_gap", int'(done), 1);
        A = a;
        B = b;
        Bin = bi;
        start = 1'b1;
        diff = int'(a) - int'(b) - int'(bi);
        q.push_back('{d: W'(((diff % 16) + 16) % 16), bo: (diff < 0), acc: cyc + 1});
        nops++;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        Bin = 1'($urandom);
        chk("busy_after_accept", int'(busy), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_D", int'(D), 0);
        chk("rst_Bout", int'(Bout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;

        issue(4'd7, 4'd3, 1'b0, 1'b0);
        issue(4'd9, 4'd6, 1'b0, 1'b1);
        issue(4'd5, 4'd8, 1'b0, 1'b1);
        issue(4'd0, 4'd0, 1'b1, 1'b1);
        issue(4'd15, 4'd15, 1'b0, 1'b1);

        issue(4'd12, 4'd5, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        A = 4'd1;
        B = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        issue(4'd6, 4'd3, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_D", int'(D), 0);
        chk("abort_Bout", int'(Bout), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        void'(q.pop_back());
        nops--;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(4'd6, 4'd3, 1'b0, 1'b0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    issue(W'(a), W'(b), 1'(c), 1'b1);

        repeat (40) issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);

        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain", q.size(), 0);
        chk("done_count", ndone, nops);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
